// File: rtl/scr1_tb_trace_fifo.sv
// Retirement trace FIFO: one entry per retiring GPR write and/or store, tagged with a
// sequence number so dropped events show up as gaps in out_seq.
module scr1_tb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       rd_en,
    input  logic [4:0]                 rd_addr,
    input  logic [31:0]                rd_wdata,
    input  logic [31:0]                pc,
    input  logic [2:0]                 mem_wen,
    input  logic [31:0]                mem_waddr,
    input  logic [31:0]                mem_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [31:0]                out_pc,
    output logic                       out_rd_v,
    output logic [4:0]                 out_rd_addr,
    output logic [31:0]                out_rd_wdata,
    output logic [2:0]                 out_mem_wen,
    output logic [31:0]                out_mem_waddr,
    output logic [31:0]                out_mem_wdata,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [31:0]      pc;
        logic             rd_v;
        logic [4:0]       rd_addr;
        logic [31:0]      rd_wdata;
        logic [2:0]       mem_wen;
        logic [31:0]      mem_waddr;
        logic [31:0]      mem_wdata;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [SEQ_W-1:0]  seq;
    logic              evt;
    logic              push;
    logic              pop;
    logic              drop;
    logic              wen_bad;

    // Handshake: the head entry transfers on a rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head holds while out_ready is low.
    always_comb begin
        evt     = rd_en | (mem_wen != 3'b000);
        pop     = out_valid & out_ready & ~flush_i;
        push    = evt & ~flush_i & ((level < LW'(DEPTH)) | pop);
        drop    = evt & ~flush_i & ~push;
        wen_bad = (mem_wen & (mem_wen - 3'd1)) != 3'b000;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            seq    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
            // Dropped events still consume a sequence number.
            if (evt) seq <= seq + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_o      <= 1'b0;
            drop_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (drop) begin
                ovf_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            if (wen_bad) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{seq:       seq,
                             pc:        pc,
                             rd_v:      rd_en,
                             rd_addr:   rd_addr,
                             rd_wdata:  rd_wdata,
                             mem_wen:   mem_wen,
                             mem_waddr: mem_waddr,
                             mem_wdata: mem_wdata};
        end
    end

    always_comb begin
        head          = mem[rd_ptr];
        out_valid     = (level != '0);
        out_seq       = head.seq;
        out_pc        = head.pc;
        out_rd_v      = head.rd_v;
        out_rd_addr   = head.rd_addr;
        out_rd_wdata  = head.rd_wdata;
        out_mem_wen   = head.mem_wen;
        out_mem_waddr = head.mem_waddr;
        out_mem_wdata = head.mem_wdata;
        level_o       = level;
    end
endmodule

// File: tb/tb_scr1_tb_trace_fifo.sv
// Bench for scr1_tb_trace_fifo: directed vector table plus hand-written fill/overflow,
// wrap-around and asynchronous-reset sequences checked against an expected queue.
module tb_scr1_tb_trace_fifo;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              rd_en = 1'b0;
    logic [4:0]        rd_addr = '0;
    logic [31:0]       rd_wdata = '0;
    logic [31:0]       pc = '0;
    logic [2:0]        mem_wen = '0;
    logic [31:0]       mem_waddr = '0;
    logic [31:0]       mem_wdata = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [SEQ_W-1:0]  out_seq;
    logic [31:0]       out_pc;
    logic              out_rd_v;
    logic [4:0]        out_rd_addr;
    logic [31:0]       out_rd_wdata;
    logic [2:0]        out_mem_wen;
    logic [31:0]       out_mem_waddr;
    logic [31:0]       out_mem_wdata;
    logic [LW-1:0]     level;
    logic              ovf;
    logic [15:0]       drop_cnt;
    logic              err;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [SEQ_W-1:0] exp_q[$];
    logic [SEQ_W-1:0] seq_m;

    scr1_tb_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .pc(pc),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_seq(out_seq), .out_pc(out_pc), .out_rd_v(out_rd_v),
        .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .out_mem_wen(out_mem_wen), .out_mem_waddr(out_mem_waddr), .out_mem_wdata(out_mem_wdata),
        .level_o(level), .ovf_o(ovf), .drop_cnt_o(drop_cnt), .err_o(err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc;
        logic [2:0]  mem_wen;
        logic [31:0] mem_waddr;
        logic [31:0] mem_wdata;
        logic        ready;
        logic        e_valid;
        logic [15:0] e_seq;
        logic [31:0] e_pc;
        logic        e_rd_v;
        logic [4:0]  e_rd_addr;
        logic [31:0] e_rd_wdata;
        logic [2:0]  e_mem_wen;
        logic [31:0] e_mem_waddr;
        logic [31:0] e_mem_wdata;
        logic [4:0]  e_level;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [2:0] w, input logic [31:0] p, input logic rdy);
        flush = 1'b0; rd_en = r; rd_addr = 5'd3; rd_wdata = p ^ 32'hA5A5_0000;
        pc = p; mem_wen = w; mem_waddr = p + 32'h1000; mem_wdata = ~p; out_ready = rdy;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        seq_m = '0;
    endtask

    initial begin
        vecs[0] = '{rd_en:1'b1, rd_addr:5'd5, rd_wdata:32'h1234, pc:32'h200,
                    e_valid:1'b1, e_seq:16'd0, e_pc:32'h200, e_rd_v:1'b1, e_rd_addr:5'd5,
                    e_rd_wdata:32'h1234, e_level:5'd1, default:'0};
        vecs[1] = '{ready:1'b1, default:'0};
        vecs[2] = '{mem_wen:3'b001, mem_waddr:32'h1000, mem_wdata:32'hAA, pc:32'h204,
                    e_valid:1'b1, e_seq:16'd1, e_pc:32'h204, e_mem_wen:3'b001,
                    e_mem_waddr:32'h1000, e_mem_wdata:32'hAA, e_level:5'd1, default:'0};
        vecs[3] = '{rd_en:1'b1, rd_addr:5'd7, rd_wdata:32'h77, pc:32'h208, ready:1'b1,
                    e_valid:1'b1, e_seq:16'd2, e_pc:32'h208, e_rd_v:1'b1, e_rd_addr:5'd7,
                    e_rd_wdata:32'h77, e_level:5'd1, default:'0};
        vecs[4] = '{mem_wen:3'b011, mem_waddr:32'h2000, mem_wdata:32'hBB, pc:32'h20C,
                    e_valid:1'b1, e_seq:16'd2, e_pc:32'h208, e_rd_v:1'b1, e_rd_addr:5'd7,
                    e_rd_wdata:32'h77, e_level:5'd2, e_err:1'b1, default:'0};
        vecs[5] = '{ready:1'b1, e_valid:1'b1, e_seq:16'd3, e_pc:32'h20C, e_mem_wen:3'b011,
                    e_mem_waddr:32'h2000, e_mem_wdata:32'hBB, e_level:5'd1, e_err:1'b1, default:'0};
        vecs[6] = '{e_valid:1'b1, e_seq:16'd3, e_pc:32'h20C, e_mem_wen:3'b011,
                    e_mem_waddr:32'h2000, e_mem_wdata:32'hBB, e_level:5'd1, e_err:1'b1, default:'0};
        vecs[7] = '{flush:1'b1, rd_en:1'b1, pc:32'h300, ready:1'b1, e_err:1'b1, default:'0};
        vecs[8] = '{rd_en:1'b1, rd_addr:5'd1, rd_wdata:32'h11, pc:32'h210,
                    e_valid:1'b1, e_seq:16'd4, e_pc:32'h210, e_rd_v:1'b1, e_rd_addr:5'd1,
                    e_rd_wdata:32'h11, e_level:5'd1, e_err:1'b1, default:'0};
        vecs[9] = '{ready:1'b1, e_err:1'b1, default:'0};

        // Reset state, checked while reset is still held
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_level", level, 0);
        check("reset_ovf", ovf, 0);
        check("reset_err", err, 0);
        check("reset_drop", drop_cnt, 0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            flush = vecs[i].flush; rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
            rd_wdata = vecs[i].rd_wdata; pc = vecs[i].pc; mem_wen = vecs[i].mem_wen;
            mem_waddr = vecs[i].mem_waddr; mem_wdata = vecs[i].mem_wdata; out_ready = vecs[i].ready;
            step();
            check($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("v%0d_level", i), level, vecs[i].e_level);
            check($sformatf("v%0d_err", i), err, vecs[i].e_err);
            check($sformatf("v%0d_ovf", i), ovf, 0);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_seq", i), out_seq, vecs[i].e_seq);
                check($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
                check($sformatf("v%0d_rd_v", i), out_rd_v, vecs[i].e_rd_v);
                check($sformatf("v%0d_rd_addr", i), out_rd_addr, vecs[i].e_rd_addr);
                check($sformatf("v%0d_rd_wdata", i), out_rd_wdata, vecs[i].e_rd_wdata);
                check($sformatf("v%0d_mem_wen", i), out_mem_wen, vecs[i].e_mem_wen);
                check($sformatf("v%0d_mem_waddr", i), out_mem_waddr, vecs[i].e_mem_waddr);
                check($sformatf("v%0d_mem_wdata", i), out_mem_wdata, vecs[i].e_mem_wdata);
            end
        end
        drive(1'b0, 3'b000, 32'h0, 1'b0);

        // Fill to full, simultaneous push/pop at full, then overflow
        pulse_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 3'b100, 32'h300 + 32'(k), 1'b0);
            exp_q.push_back(seq_m); seq_m++;
            step();
        end
        check("full_level", level, DEPTH);
        check("full_ovf", ovf, 0);
        drive(1'b0, 3'b100, 32'h400, 1'b1);
        check("fullpp_head", out_seq, exp_q.pop_front());
        exp_q.push_back(seq_m); seq_m++;
        step();
        check("fullpp_level", level, DEPTH);
        check("fullpp_drop", drop_cnt, 0);
        check("fullpp_ovf", ovf, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 3'b100, 32'h500 + 32'(k), 1'b0);
            seq_m++;
            step();
        end
        check("ovf_level", level, DEPTH);
        check("ovf_flag", ovf, 1);
        check("ovf_drop", drop_cnt, 2);
        drive(1'b0, 3'b000, 32'h0, 1'b1);
        for (int k = 0; k < DEPTH + 4 && exp_q.size() != 0; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_seq", out_seq, exp_q.pop_front());
            step();
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_level", level, 0);
        check("drain_ovf_sticky", ovf, 1);

        // Interleaved push/pop with random out_ready; pointers wrap several times
        begin
            int pushes = 0;
            int cycles = 0;
            while ((pushes < 40 || exp_q.size() != 0) && cycles < 1000) begin
                logic rdy;
                logic ev;
                logic pop_m;
                rdy = 1'($urandom_range(0, 1));
                pop_m = rdy && (exp_q.size() != 0);
                ev = (pushes < 40) && ($urandom_range(0, 3) != 0) && (exp_q.size() < DEPTH || pop_m);
                drive(1'b0, ev ? 3'b010 : 3'b000, 32'h800 + 32'(pushes), rdy);
                check("wrap_valid", out_valid, exp_q.size() != 0);
                check("wrap_level", level, exp_q.size());
                if (pop_m) check("wrap_seq", out_seq, exp_q.pop_front());
                if (ev) begin
                    exp_q.push_back(seq_m); seq_m++; pushes++;
                end
                step();
                cycles++;
            end
            check("wrap_done_in_budget", (cycles < 1000), 1);
            check("wrap_drop_unchanged", drop_cnt, 2);
        end

        // Asynchronous reset between edges with pending entries
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 3'b000, 32'h900 + 32'(k), 1'b0);
            step();
        end
        drive(1'b0, 3'b000, 32'h0, 1'b0);
        check("pre_rst_level", level, 7);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_level", level, 0);
        check("async_rst_ovf", ovf, 0);
        check("async_rst_drop", drop_cnt, 0);
        #1 rst = 1'b0;
        drive(1'b1, 3'b000, 32'hA00, 1'b0);
        step();
        drive(1'b0, 3'b000, 32'h0, 1'b0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_seq", out_seq, 0);
        check("post_rst_pc", out_pc, 32'hA00);
        check("post_rst_level", level, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
